// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage types: state encoding, bus bundles and reset PC.
package fetch_ctrl_pkg;

   typedef logic        u1;
   typedef logic [31:0] u32;
   typedef logic [63:0] u64;

   localparam u64 PC_RESET = 64'h8000_0000;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      u1  valid;
      u64 pc;
      u32 instr;
   } fetch_out_t;

   typedef struct packed {
      u1  valid;
      u64 addr;
   } ibus_req_t;

   typedef struct packed {
      u1  data_ok;
      u32 data;
   } ibus_resp_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction bus: one outstanding request, address held until data_ok.
interface fetch_ctrl_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   logic               ireq_valid;
   logic [ADDR_W-1:0]  ireq_addr;
   logic               iresp_data_ok;
   logic [INSTR_W-1:0] iresp_data;

   modport master (
      output ireq_valid,
      output ireq_addr,
      input  iresp_data_ok,
      input  iresp_data
   );

   modport slave (
      input  ireq_valid,
      input  ireq_addr,
      output iresp_data_ok,
      output iresp_data
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, drives the ibus and feeds the F/D register.
// Flushes kill in-flight responses; stalls park a response in a 1-entry buffer.
module fetch_ctrl #(
   parameter logic [63:0] PC_RESET = fetch_ctrl_pkg::PC_RESET,
   parameter int          ADDR_W   = 64,
   parameter int          INSTR_W  = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               stallF,
   input  logic               flushF,
   input  logic [ADDR_W-1:0]  redirect_pc,
   fetch_ctrl_if.master       ibus,
   output logic               out_valid,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [INSTR_W-1:0] out_instr
);
   import fetch_ctrl_pkg::*;

   localparam logic [ADDR_W-1:0] RST_PC = PC_RESET[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  req_q, req_d;
   logic [ADDR_W-1:0]  bpc_q, bpc_d;
   logic [INSTR_W-1:0] bins_q, bins_d;

   logic               dlv;
   logic [ADDR_W-1:0]  dpc;
   logic [INSTR_W-1:0] dins;
   logic               ok;

   assign ok             = ibus.iresp_data_ok;
   assign ibus.ireq_addr = req_q;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      req_d           = req_q;
      bpc_d           = bpc_q;
      bins_d          = bins_q;
      dlv             = 1'b0;
      dpc             = req_q;
      dins            = ibus.iresp_data;
      ibus.ireq_valid = (state_q != HOLD);
      unique case (state_q)
         FETCH: begin
            if (flushF && ok) begin
               pc_d  = redirect_pc;
               req_d = redirect_pc;
            end else if (flushF) begin
               pc_d    = redirect_pc;
               state_d = DISCARD;
            end else if (ok && stallF) begin
               bpc_d   = req_q;
               bins_d  = ibus.iresp_data;
               pc_d    = req_q + STEP;
               state_d = HOLD;
            end else if (ok) begin
               dlv   = 1'b1;
               pc_d  = req_q + STEP;
               req_d = req_q + STEP;
            end
         end
         HOLD: begin
            if (flushF) begin
               pc_d    = redirect_pc;
               req_d   = redirect_pc;
               state_d = FETCH;
            end else if (!stallF) begin
               dlv     = 1'b1;
               dpc     = bpc_q;
               dins    = bins_q;
               req_d   = pc_q;
               state_d = FETCH;
            end
         end
         DISCARD: begin
            if (flushF) pc_d = redirect_pc;
            // a redirect landing with the dropped response becomes the new fetch
            if (ok) begin
               req_d   = flushF ? redirect_pc : pc_q;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= FETCH;
         pc_q    <= RST_PC;
         req_q   <= RST_PC;
         bpc_q   <= '0;
         bins_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         bpc_q   <= bpc_d;
         bins_q  <= bins_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_instr <= '0;
      end else if (flushF) begin
         out_valid <= 1'b0;
      end else if (!stallF) begin
         out_valid <= dlv;
         if (dlv) begin
            out_pc    <= dpc;
            out_instr <= dins;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and random checks of fetch_ctrl against a transaction-level model.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        stallF = 1'b0;
   logic        flushF = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;

   int n_assert = 0;
   int n_fail   = 0;

   fetch_ctrl_if #(.ADDR_W(64), .INSTR_W(32)) ibus ();

   fetch_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .stallF      (stallF),
      .flushF      (flushF),
      .redirect_pc (redirect_pc),
      .ibus        (ibus.master),
      .out_valid   (out_valid),
      .out_pc      (out_pc),
      .out_instr   (out_instr)
   );

   always #5 clk = ~clk;

   // model: one outstanding request, a kill flag with its pending target,
   // and a queue of at most one parked instruction
   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } item_t;

   item_t       parked[$];
   logic [63:0] m_req;
   logic [63:0] m_tgt;
   bit          m_killed;
   bit          m_ov;
   logic [63:0] m_opc;
   logic [31:0] m_oin;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      parked.delete();
      m_req    = 64'h8000_0000;
      m_tgt    = '0;
      m_killed = 0;
      m_ov     = 0;
      m_opc    = '0;
      m_oin    = '0;
   endtask

   function automatic bit m_busy();
      return parked.size() == 0;
   endfunction

   task automatic model_step(input bit st, input bit fl,
                             input logic [63:0] rd,
                             input bit ok, input logic [31:0] d);
      bit    dlv;
      item_t it;
      dlv = 0;
      if (fl) begin
         m_ov = 0;
         if (parked.size() != 0) begin
            parked.delete();
            m_req = rd;
         end else if (m_killed) begin
            m_tgt = rd;
            if (ok) begin
               m_req    = rd;
               m_killed = 0;
            end
         end else if (ok) begin
            m_req = rd;
         end else begin
            m_killed = 1;
            m_tgt    = rd;
         end
      end else begin
         if (parked.size() != 0) begin
            if (!st) begin
               it    = parked.pop_front();
               dlv   = 1;
               m_opc = it.pc;
               m_oin = it.instr;
               m_req = it.pc + 64'd4;
            end
         end else if (m_killed) begin
            if (ok) begin
               m_req    = m_tgt;
               m_killed = 0;
            end
         end else if (ok && st) begin
            it.pc    = m_req;
            it.instr = d;
            parked.push_back(it);
         end else if (ok) begin
            dlv   = 1;
            m_opc = m_req;
            m_oin = d;
            m_req = m_req + 64'd4;
         end
         if (!st) m_ov = dlv;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ireq_valid"}, 64'(ibus.ireq_valid), 64'(m_busy()));
      if (m_busy())
         chk({tag, ".ireq_addr"}, ibus.ireq_addr, m_req);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
         chk({tag, ".out_pc"}, out_pc, m_opc);
         chk({tag, ".out_instr"}, 64'(out_instr), 64'(m_oin));
      end
   endtask

   // called at a negedge; returns at the following negedge
   task automatic cyc(input string tag, input bit st, input bit fl,
                      input logic [63:0] rd,
                      input bit ok, input logic [31:0] d);
      stallF             = st;
      flushF             = fl;
      redirect_pc        = rd;
      ibus.iresp_data_ok = ok;
      ibus.iresp_data    = d;
      #1;
      check_all(tag);
      @(posedge clk);
      model_step(st, fl, rd, ok, d);
      @(negedge clk);
      stallF             = 0;
      flushF             = 0;
      ibus.iresp_data_ok = 0;
      #1;
   endtask

   task automatic do_reset();
      resetn             = 0;
      stallF             = 0;
      flushF             = 0;
      ibus.iresp_data_ok = 0;
      ibus.iresp_data    = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1;
   endtask

   initial begin
      logic [63:0] rd;
      bit          st, fl, ok;
      ibus.iresp_data_ok = 0;
      ibus.iresp_data    = '0;
      do_reset();

      #1;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.out_pc", out_pc, 64'd0);
      chk("rst.out_instr", 64'(out_instr), 64'd0);
      chk("rst.ireq_addr", ibus.ireq_addr, 64'h8000_0000);
      @(negedge clk);

      // streaming, one per cycle
      cyc("s0", 0, 0, 0, 1, 32'h13);
      cyc("s1", 0, 0, 0, 1, 32'h13);
      chk("s.addr2", ibus.ireq_addr, 64'h8000_0008);
      chk("s.opc1", out_pc, 64'h8000_0004);
      cyc("s2", 0, 0, 0, 1, 32'h13);
      chk("s.opc2", out_pc, 64'h8000_0008);

      // stall parks a response
      do_reset();
      @(negedge clk);
      cyc("h0", 0, 0, 0, 1, 32'h13);
      cyc("h1", 1, 0, 0, 1, 32'hDEAD_BEEF);
      chk("h.ireq_valid", 64'(ibus.ireq_valid), 64'd0);
      cyc("h2", 1, 0, 0, 0, 0);
      cyc("h3", 1, 0, 0, 0, 0);
      chk("h.frozen_pc", out_pc, 64'h8000_0000);
      cyc("h4", 0, 0, 0, 0, 0);
      chk("h.out_pc", out_pc, 64'h8000_0004);
      chk("h.out_instr", 64'(out_instr), 64'hDEAD_BEEF);
      cyc("h5", 0, 0, 0, 0, 0);
      chk("h.once", 64'(out_valid), 64'd0);

      // flush with a request outstanding
      cyc("f0", 0, 1, 64'h8000_1000, 0, 0);
      chk("f.hold_addr", ibus.ireq_addr, 64'h8000_0008);
      cyc("f1", 0, 0, 0, 0, 0);
      cyc("f2", 0, 0, 0, 1, 32'h0BAD);
      chk("f.new_addr", ibus.ireq_addr, 64'h8000_1000);
      chk("f.dropped", 64'(out_valid), 64'd0);

      // flush and data_ok together, then flush with stall
      cyc("g0", 0, 1, 64'h8000_2000, 1, 32'h0BAD);
      chk("g.addr", ibus.ireq_addr, 64'h8000_2000);
      cyc("g1", 1, 1, 64'h8000_3000, 1, 32'h0BAD);
      chk("g.flush_wins", ibus.ireq_addr, 64'h8000_3000);

      // two redirects while discarding
      cyc("d0", 0, 1, 64'h100, 0, 0);
      cyc("d1", 0, 1, 64'h200, 0, 0);
      cyc("d2", 0, 0, 0, 1, 32'h0BAD);
      chk("d.latest", ibus.ireq_addr, 64'h200);

      // wrap and reset mid-HOLD
      cyc("w0", 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
      cyc("w1", 0, 0, 0, 1, 32'h13);
      chk("w.wrap", ibus.ireq_addr, 64'h0);
      cyc("w2", 1, 0, 0, 1, 32'h77);
      #2;
      resetn = 0;
      model_reset();
      #1;
      chk("r.out_valid", 64'(out_valid), 64'd0);
      chk("r.ireq_valid", 64'(ibus.ireq_valid), 64'd1);
      chk("r.ireq_addr", ibus.ireq_addr, 64'h8000_0000);
      @(negedge clk);
      resetn = 1;
      @(negedge clk);
      #1;

      for (int i = 0; i < 400; i++) begin
         st = ($urandom_range(0, 9) < 3);
         fl = ($urandom_range(0, 9) == 0);
         ok = m_busy() && ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 15) == 0) rd = 64'hFFFF_FFFF_FFFF_FFFC;
         else rd = {32'($urandom), 32'($urandom)} & ~64'd3;
         cyc("rnd", st, fl, rd, ok, 32'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage controller: owns the PC, issues instruction requests on the ibus, and presents fetched {pc, instr} to the F/D pipeline register. It is the consumer of the hazard unit's stallF/flushF and the execute-stage redirect. It must never lose, duplicate or misattribute an instruction across stalls, flushes and in-flight bus responses.

Parameters:
PC_RESET, 64'h8000_0000, PC value loaded on reset.
ADDR_W, 64, PC and bus address width.
INSTR_W, 32, instruction width.

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
stallF  in  1  hazard: hold fetch output and PC
flushF  in  1  hazard: kill current fetch and redirect (ebranch)
redirect_pc  in  ADDR_W  branch target; sampled only when flushF=1
ireq_valid  out  1  ibus request valid
ireq_addr  out  ADDR_W  ibus request address
iresp_data_ok  in  1  ibus response valid for the outstanding request
iresp_data  in  INSTR_W  ibus response instruction
out_valid  out  1  fetched instruction valid toward F/D register
out_pc  out  ADDR_W  PC of out_instr
out_instr  out  INSTR_W  fetched instruction

Behaviour:
- Reset (async, resetn=0): state=FETCH, pc=PC_RESET, req_addr=PC_RESET, out_valid=0, out_pc=0, out_instr=0, buffer cleared. ibus shares the reset domain, so no stale response is expected after reset.
- Bus rule: once ireq_valid=1, ireq_addr is held stable until iresp_data_ok=1. A request is never retracted. At most one request is outstanding.
- Registers: pc is the next address to fetch. req_addr is the address of the outstanding request. buf_instr and buf_pc form a one-entry hold buffer.
- States:
  - FETCH: ireq_valid=1, ireq_addr=req_addr (equals pc on entry).
  - HOLD: ireq_valid=0, instruction parked in buffer.
  - DISCARD: ireq_valid=1, ireq_addr=req_addr, response will be dropped.
- FETCH transitions, evaluated in priority order:
  - flushF & data_ok: drop response; pc=req_addr=redirect_pc; stay FETCH.
  - flushF & !data_ok: pc=redirect_pc; go DISCARD; req_addr unchanged.
  - data_ok & stallF: buf={req_addr, iresp_data}; pc=req_addr+4; go HOLD.
  - data_ok & !stallF: out_valid=1, out_pc=req_addr, out_instr=iresp_data; pc=req_addr=req_addr+4.
  - otherwise: wait.
- HOLD:
  - flushF: drop buffer; pc=req_addr=redirect_pc; go FETCH.
  - !stallF: out={1, buf_pc, buf_instr}; req_addr=pc; go FETCH.
- DISCARD:
  - flushF: pc=redirect_pc (latest target wins).
  - data_ok: drop response; req_addr=pc; go FETCH. A flushF in the same cycle uses redirect_pc as the new req_addr.
- Output registers, every cycle:
  - flushF=1 forces out_valid=0.
  - Otherwise stallF=1 holds out_* unchanged.
  - Otherwise out_* update per the transitions above; with no delivery, out_valid=0.
- flushF has priority over stallF in all states.
- Latency: delivery appears on out_* one cycle after the data_ok edge. Back-to-back data_ok gives one instruction per cycle.
- Arithmetic: pc+4 is modulo 2^ADDR_W, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. redirect_pc is taken verbatim, with no alignment check.

Decomposition:
- Package pipes holds:
  - fetch_state_t enum {FETCH, HOLD, DISCARD}
  - fetch_out_t struct {valid, pc, instr}
  - the PC_RESET constant
  - ibus_req_t {valid, addr} and ibus_resp_t {data_ok, data}, if not already present
- Widths use the common u1/u32/u64 types.
- No sub-module needed; optionally split out fetch_buf (the one-entry hold buffer).

Test Plan:
- Reset, data_ok every cycle, instr 0x13 -> ireq_addr sequence 0x80000000, 0x80000004, 0x80000008; out_pc follows one cycle later with out_valid=1.
- data_ok with stallF=1 for 3 cycles, instr 0xDEADBEEF at 0x80000004 -> ireq_valid=0 during HOLD, out_* frozen; after stallF=0, out_pc=0x80000004, out_instr=0xDEADBEEF exactly once.
- flushF with redirect_pc=0x80001000 while a request is outstanding, data_ok 2 cycles later -> ireq_addr stays at the old value until data_ok, the response is never on out_*, next ireq_addr=0x80001000.
- flushF and data_ok in the same cycle -> response dropped, out_valid=0, next ireq_addr=redirect_pc; flushF+stallF together -> flush wins.
- Two flushF pulses in DISCARD (targets 0x100 then 0x200) -> the fetch after discard uses 0x200.
- Redirect to 0xFFFFFFFFFFFFFFFC -> next fetch addr 0x0; resetn pulsed low mid-HOLD -> out_valid=0 immediately, ireq_addr=0x80000000.
